// File: rtl/cache_pkg.sv
// ============================================================================
// cache_pkg : FSM states, word-mode constant and geometry for data_cache.
// Rev 1.0
// ============================================================================
`include "def.sv"
`default_nettype none
package cache_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_RESP = 2'd3
  } cache_state_e;

  localparam int DEF_SETS       = 256;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int OFFSET_W       = 2;
  localparam int INDEX_W        = $clog2(DEF_SETS);
  localparam int TAG_W          = DEF_ADDR_WIDTH - OFFSET_W - INDEX_W;

  localparam logic [2:0] WORD_MODE = `DATA_ADDR_MODE_W;

  function automatic logic is_byte_mode(input logic [2:0] mode);
    return (mode == `DATA_ADDR_MODE_B) || (mode == `DATA_ADDR_MODE_BU);
  endfunction
endpackage
`default_nettype wire

// File: rtl/cache_store.sv
// ============================================================================
// cache_store : tag/valid/data arrays, async read, byte-enabled sync write.
// Rev 1.0
// ============================================================================
`default_nettype none
module cache_store #(
  parameter int SETS  = 256,
  parameter int TAG_W = 22,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_be,
  input  logic             wr_fill,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx0,
  input  logic [IDX_W-1:0] inv_idx1
);
  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  valid_d;
  logic [TAG_W-1:0] tag_mem [SETS];

  always_comb begin
    valid_d = valid_q;
    if (wr_fill) valid_d[wr_idx] = 1'b1;
    if (inv_en) begin
      valid_d[inv_idx0] = 1'b0;
      valid_d[inv_idx1] = 1'b0;
    end
    if (clr) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  // Clear also blocks writes so an abandoned refill leaves no trace.
  always_ff @(posedge clk) begin
    if (!clr && wr_fill) tag_mem[wr_idx] <= wr_tag;
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] lane_mem [SETS];
    always_ff @(posedge clk) begin
      if (!clr && wr_be[b]) lane_mem[wr_idx] <= wr_data[8*b +: 8];
    end
    assign rd_data[8*b +: 8] = lane_mem[rd_idx];
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
endmodule
`default_nettype wire

// File: rtl/def.sv
// ============================================================================
// def.sv : shared access-size encodings for CPU and data-memory ports.
// Rev 1.0
// ============================================================================
`default_nettype none
`ifndef DEF_SV
`define DEF_SV
`define DATA_ADDR_MODE_B  3'b000
`define DATA_ADDR_MODE_H  3'b001
`define DATA_ADDR_MODE_W  3'b010
`define DATA_ADDR_MODE_BU 3'b100
`define DATA_ADDR_MODE_HU 3'b101
`endif
`default_nettype wire

// File: rtl/data_cache.sv
// ============================================================================
// data_cache : direct-mapped write-through, no-allocate data cache.
// Rev 1.0
// ============================================================================
`include "def.sv"
`default_nettype none
module data_cache
  import cache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [2:0]            AddrMode,
  input  logic [31:0]           cpu_wd,
  output logic [31:0]           cpu_rd,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wd,
  output logic                  mem_we,
  output logic [2:0]            mem_addrmode,
  output logic                  miss,
  input  logic                  cache_en,
  input  logic [31:0]           mem_rd
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TW    = ADDR_WIDTH - OFFSET_W - IDX_W;

  cache_state_e state_q, state_d;
  logic [31:0]  bypass_q, bypass_d;
  logic         bypass_mode_q, bypass_mode_d;

  logic [1:0]       offset;
  logic [IDX_W-1:0] idx;
  logic [TW-1:0]    tag;
  logic             byte_mode, aligned, line_hit;
  logic             rd_valid;
  logic [TW-1:0]    rd_tag;
  logic [31:0]      rd_data, load_data;
  logic [7:0]       sel_byte;
  logic [3:0]       wr_be;
  logic             wr_fill, inv_en;
  logic [31:0]      wr_data;

  assign offset    = cpu_addr[1:0];
  assign idx       = cpu_addr[OFFSET_W +: IDX_W];
  assign tag       = cpu_addr[ADDR_WIDTH-1 -: TW];
  assign byte_mode = is_byte_mode(AddrMode);
  assign aligned   = (offset == 2'b00);
  assign line_hit  = rd_valid && (rd_tag == tag);
  assign sel_byte  = rd_data[{offset, 3'b000} +: 8];

  always_comb begin
    if (AddrMode == `DATA_ADDR_MODE_B)       load_data = {{24{sel_byte[7]}}, sel_byte};
    else if (AddrMode == `DATA_ADDR_MODE_BU) load_data = {24'h0, sel_byte};
    else                                     load_data = rd_data;
  end

  always_comb begin
    state_d       = state_q;
    bypass_d      = bypass_q;
    bypass_mode_d = bypass_mode_q;
    cpu_rd        = load_data;
    stall         = 1'b0;
    miss          = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = cpu_addr;
    mem_wd        = cpu_wd;
    mem_addrmode  = AddrMode;
    wr_be         = 4'b0000;
    wr_fill       = 1'b0;
    wr_data       = cpu_wd;
    inv_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_we) begin
          mem_we = 1'b1;
          if (byte_mode) begin
            wr_data = {4{cpu_wd[7:0]}};
            if (line_hit) wr_be = 4'b0001 << offset;
          end else if (aligned) begin
            if (line_hit) wr_be = 4'b1111;
          end else begin
            // Unaligned word spans two lines; drop both rather than merge.
            inv_en = 1'b1;
          end
        end else if (cpu_re) begin
          if (!((byte_mode || aligned) && line_hit)) begin
            stall         = 1'b1;
            state_d       = S_REQ;
            bypass_mode_d = !(byte_mode || aligned);
          end
        end
      end
      S_REQ, S_FILL: begin
        miss         = 1'b1;
        stall        = 1'b1;
        mem_addrmode = WORD_MODE;
        mem_addr     = bypass_mode_q ? cpu_addr : {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        if (state_q == S_REQ) begin
          state_d = S_FILL;
        end else if (cache_en) begin
          if (bypass_mode_q) begin
            bypass_d = mem_rd;
            state_d  = S_RESP;
          end else begin
            wr_be   = 4'b1111;
            wr_fill = 1'b1;
            wr_data = mem_rd;
            state_d = S_IDLE;
          end
        end
      end
      S_RESP: begin
        cpu_rd  = bypass_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      bypass_q      <= '0;
      bypass_mode_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bypass_q      <= bypass_d;
      bypass_mode_q <= bypass_mode_d;
    end
  end

  cache_store #(
    .SETS  (SETS),
    .TAG_W (TW),
    .IDX_W (IDX_W)
  ) u_store (
    .clk      (clk),
    .clr      (!rst_n),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_idx   (idx),
    .wr_be    (wr_be),
    .wr_fill  (wr_fill),
    .wr_tag   (tag),
    .wr_data  (wr_data),
    .inv_en   (inv_en),
    .inv_idx0 (idx),
    .inv_idx1 (idx + IDX_W'(1))
  );
endmodule
`default_nettype wire

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL take parameter SETS, default 256: number of direct-mapped lines; one 32-bit word per line.
REQ-002 SHALL take parameter ADDR_WIDTH, default 32: CPU and memory address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cpu_addr  in  32  byte address of the load or store.
REQ-006 cpu_re / cpu_we  in  1 each  load request / store request; cpu_we has priority when both are high.
REQ-007 AddrMode  in  3  access size, using the `DATA_ADDR_MODE_*` encodings: B (signed byte), BU (unsigned byte), all other values mean word.
REQ-008 cpu_wd  in  32  store data.
REQ-009 cpu_rd  out  32  load data, extended per AddrMode.
REQ-010 stall  out  1  CPU must hold its request while this is high.
REQ-011 mem_addr / mem_wd  out  32 each  address and write data driven to data memory.
REQ-012 mem_we  out  1  data-memory write enable.
REQ-013 mem_addrmode  out  3  access mode driven to data memory.
REQ-014 miss  out  1  refill request to data memory.
REQ-015 cache_en  in  1  memory acknowledge; this is miss registered by the memory, so it arrives one cycle after miss.
REQ-016 mem_rd  in  32  combinational read data from memory for mem_addr.

Function
REQ-017 Address split SHALL be: offset = addr[1:0], index = addr[9:2], tag = addr[31:10]; tag width = ADDR_WIDTH-2-log2(SETS).
REQ-018 FSM states SHALL be IDLE, REQ, FILL, RESP.
REQ-019 A hit is: state IDLE, cpu_re high, line valid, tags equal, and either a byte mode or a word access with offset 0. On a hit, cpu_rd SHALL be combinational in the same cycle and stall SHALL be 0.
REQ-020 Byte loads SHALL select byte[offset] of the line word; B sign-extends bit 7, BU zero-extends.
REQ-021 Read miss in IDLE: stall=1 that same cycle, next state REQ.
REQ-022 In REQ and FILL: miss=1, mem_addr={cpu_addr[31:2],2'b00}, mem_addrmode=word, stall=1.
- REQ always advances to FILL.
- FILL waits until cache_en=1, then writes tag, data=mem_rd and valid=1, and returns to IDLE.
- The retried access then hits.
- Cycle count: miss at t, REQ at t+1, FILL with cache_en at t+2, hit at t+3.
REQ-023 A word load with offset != 0 SHALL bypass the cache.
- It follows the REQ/FILL sequence but with mem_addr=cpu_addr unaligned.
- In FILL it latches mem_rd into a bypass register instead of writing the array.
- It then moves to RESP: cpu_rd = bypass register, stall=0 for one cycle, then IDLE.
REQ-024 Stores SHALL be write-through, no-allocate, and never stall.
- In IDLE with cpu_we=1: mem_we=1, mem_addr=cpu_addr, mem_wd=cpu_wd, mem_addrmode=AddrMode, all in the same cycle.
REQ-025 Store hit, byte mode: only byte[offset] of the line SHALL be updated.
REQ-026 Store hit, aligned word: the whole line SHALL be updated.
REQ-027 Store miss: no array change.
REQ-028 Word store with offset != 0: lines index and index+1 SHALL be invalidated; index+1 wraps SETS-1 -> 0.
REQ-029 mem_we SHALL be 0 in every state other than IDLE.
REQ-030 miss SHALL be 0 in IDLE and RESP.
REQ-031 If cache_en=1 while in IDLE or REQ, it SHALL be ignored.

Reset
REQ-032 With rst_n=0 at a clock edge:
- state -> IDLE;
- all valid bits -> 0;
- bypass register -> 0;
- outputs next cycle: stall=0, miss=0, mem_we=0.
REQ-033 Reset during REQ or FILL SHALL abandon the refill with no array write; a cache_en arriving after reset SHALL be ignored.
REQ-034 Tag and data arrays need not be reset.

Structure
REQ-035 The FSM state enum, the word-mode constant and the geometry localparams (index/tag widths) SHALL live in a shared package cache_pkg; AddrMode encodings remain in def.sv.
REQ-036 Tag, valid and data storage SHALL be one sub-module, cache_store:
- combinational read by index;
- synchronous write with a per-byte enable;
- invalidate port for two indices;
- synchronous clear of valid bits.

Verification
REQ-037 After reset, word load at 0x00010000 with memory word 0xDEADBEEF: miss high at cycles t+1..t+2, cache_en at t+2, cpu_rd=0xDEADBEEF with stall=0 at t+3; a repeat load hits in 1 cycle with miss=0.
REQ-038 After REQ-037, byte loads at 0x00010003: B gives 0xFFFFFFDE, BU gives 0x000000DE; both hit.
REQ-039 Byte store 0x55 to 0x00010001 (line valid): mem_we=1 for one cycle; a following word load gives 0xDEAD55EF with no miss.
REQ-040 Word load at 0x00010002 (unaligned): bypass path; RESP cycle returns memory's unaligned word; line 0x00010000 state unchanged.
REQ-041 Unaligned word store at 0x00010002, then load at 0x00010000 and at 0x00010004: both miss (lines invalidated).
REQ-042 Assert rst_n=0 during FILL: no fill occurs; the next load to the same address misses again.
